// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-stage hazard interface: the pipeline (master) presents the decode
// instruction, the hazard unit (slave) returns stall, flush and forward controls.
interface pipeline_hazard_ctrl_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   validD;
    logic [4:0]             rsD;
    logic [4:0]             rtD;
    logic                   RSDpdD;
    logic                   RTDpdD;
    logic                   RegWriteD;
    logic                   MemtoRegD;
    logic [4:0]             WriteRegD;
    logic                   BranchD;
    logic                   JumpRegD;
    logic                   TakenD;
    logic                   StallF;
    logic                   StallD;
    logic                   FlushD;
    logic                   FlushE;
    logic [1:0]             ForwardAD;
    logic [1:0]             ForwardBD;
    logic [1:0]             ForwardAE;
    logic [1:0]             ForwardBE;
    logic [STALL_CNT_W-1:0] StallCnt;

    modport master (
        output validD, rsD, rtD, RSDpdD, RTDpdD, RegWriteD, MemtoRegD,
               WriteRegD, BranchD, JumpRegD, TakenD,
        input  StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD,
               ForwardAE, ForwardBE, StallCnt
    );

    modport slave (
        input  validD, rsD, rtD, RSDpdD, RTDpdD, RegWriteD, MemtoRegD,
               WriteRegD, BranchD, JumpRegD, TakenD,
        output StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD,
               ForwardAE, ForwardBE, StallCnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard unit: tracks in-flight register writes in a small
// EX/MEM/WB scoreboard and derives stalls, flushes and forwarding selects.
module pipeline_hazard_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef struct packed {
        logic       v;
        logic [4:0] wreg;
        logic       ld;
    } sbEntry_t;

    sbEntry_t               r_ex;
    sbEntry_t               r_mem;
    sbEntry_t               r_wb;
    logic [1:0]             r_fwdAE;
    logic [1:0]             r_fwdBE;
    logic [STALL_CNT_W-1:0] r_stallCnt;

    logic       w_active;
    logic       w_loadUse;
    logic       w_branchHaz;
    logic       w_stall;
    logic       w_enterEx;
    logic [1:0] w_fwdAENext;
    logic [1:0] w_fwdBENext;

    function automatic logic srcMatch(input sbEntry_t e, input logic [4:0] src,
                                      input logic pd);
        return e.v && (e.wreg == src) && (src != 5'd0) && pd;
    endfunction

    // The nearer stage may only forward an ALU result; a load there has no data yet.
    function automatic logic [1:0] fwdSel(input sbEntry_t nearE, input sbEntry_t farE,
                                          input logic [4:0] src, input logic pd);
        logic [1:0] sel;
        sel = 2'b00;
        if (srcMatch(nearE, src, pd) && !nearE.ld)
            sel = 2'b01;
        else if (srcMatch(farE, src, pd))
            sel = 2'b10;
        return sel;
    endfunction

    assign w_active  = hz.validD & ~reset;
    assign w_loadUse = r_ex.ld & (srcMatch(r_ex, hz.rsD, hz.RSDpdD) |
                                  srcMatch(r_ex, hz.rtD, hz.RTDpdD));
    assign w_branchHaz = (hz.BranchD | hz.JumpRegD) &
                         (srcMatch(r_ex, hz.rsD, hz.RSDpdD) |
                          srcMatch(r_ex, hz.rtD, hz.RTDpdD) |
                          (r_mem.ld & (srcMatch(r_mem, hz.rsD, hz.RSDpdD) |
                                       srcMatch(r_mem, hz.rtD, hz.RTDpdD))));
    assign w_stall   = w_active & (w_loadUse | w_branchHaz);
    assign w_enterEx = hz.validD & ~w_stall;

    // EX selects look one stage ahead: today's EX entry is tomorrow's MEM, today's MEM is tomorrow's WB.
    assign w_fwdAENext = fwdSel(r_ex, r_mem, hz.rsD, hz.RSDpdD);
    assign w_fwdBENext = fwdSel(r_ex, r_mem, hz.rtD, hz.RTDpdD);

    assign hz.StallF    = w_stall;
    assign hz.StallD    = w_stall;
    assign hz.FlushE    = w_stall;
    assign hz.FlushD    = hz.TakenD & w_active & ~w_stall;
    assign hz.ForwardAD = w_active ? fwdSel(r_mem, r_wb, hz.rsD, hz.RSDpdD) : 2'b00;
    assign hz.ForwardBD = w_active ? fwdSel(r_mem, r_wb, hz.rtD, hz.RTDpdD) : 2'b00;
    assign hz.ForwardAE = r_fwdAE;
    assign hz.ForwardBE = r_fwdBE;
    assign hz.StallCnt  = r_stallCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex       <= '0;
            r_mem      <= '0;
            r_wb       <= '0;
            r_fwdAE    <= 2'b00;
            r_fwdBE    <= 2'b00;
            r_stallCnt <= '0;
        end else begin
            r_wb       <= r_mem;
            r_mem      <= r_ex;
            r_ex.v     <= hz.validD & hz.RegWriteD & ~w_stall;
            r_ex.wreg  <= hz.WriteRegD;
            r_ex.ld    <= hz.MemtoRegD;
            r_fwdAE    <= w_enterEx ? w_fwdAENext : 2'b00;
            r_fwdBE    <= w_enterEx ? w_fwdBENext : 2'b00;
            if (w_stall && (r_stallCnt != '1))
                r_stallCnt <= r_stallCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl with a narrow stall
// counter so saturation can be reached quickly.
module tb_pipeline_hazard_ctrl;

    localparam int CW = 4;

    typedef struct {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rp;
        logic       tp;
        logic       rw;
        logic       ld;
        logic [4:0] wr;
        logic       br;
        logic       jr;
        logic       tk;
        logic       st;
        logic       fd;
        logic [1:0] fad;
        logic [1:0] fbd;
        logic [1:0] fae;
        logic [1:0] fbe;
        logic [CW-1:0] cnt;
    } vec_t;

    logic clk;
    logic reset;
    int   totalChecks;
    int   passedChecks;
    vec_t tbl[$];

    pipeline_hazard_ctrl_if #(.STALL_CNT_W(CW)) hz();

    pipeline_hazard_ctrl #(.STALL_CNT_W(CW)) dut (
        .clk  (clk),
        .reset(reset),
        .hz   (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input int rs, input int rt,
                                input logic rp, input logic tp, input logic rw,
                                input logic ld, input int wr, input logic br,
                                input logic jr, input logic tk, input logic st,
                                input logic fd, input int fad, input int fbd,
                                input int fae, input int fbe, input int cnt);
        vec_t r;
        r.v = v; r.rs = rs[4:0]; r.rt = rt[4:0]; r.rp = rp; r.tp = tp;
        r.rw = rw; r.ld = ld; r.wr = wr[4:0]; r.br = br; r.jr = jr; r.tk = tk;
        r.st = st; r.fd = fd; r.fad = fad[1:0]; r.fbd = fbd[1:0];
        r.fae = fae[1:0]; r.fbe = fbe[1:0]; r.cnt = cnt[CW-1:0];
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        totalChecks++;
        if (act != req)
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        else
            passedChecks++;
    endtask

    task automatic applyStimulus(input vec_t t);
        hz.validD    = t.v;
        hz.rsD       = t.rs;
        hz.rtD       = t.rt;
        hz.RSDpdD    = t.rp;
        hz.RTDpdD    = t.tp;
        hz.RegWriteD = t.rw;
        hz.MemtoRegD = t.ld;
        hz.WriteRegD = t.wr;
        hz.BranchD   = t.br;
        hz.JumpRegD  = t.jr;
        hz.TakenD    = t.tk;
    endtask

    // Samples on the falling edge, then steps just past the next rising edge.
    task automatic checkOutput(input vec_t t, input string tag);
        @(negedge clk);
        chk({tag, ".StallF"},    int'(hz.StallF),    int'(t.st));
        chk({tag, ".StallD"},    int'(hz.StallD),    int'(t.st));
        chk({tag, ".FlushE"},    int'(hz.FlushE),    int'(t.st));
        chk({tag, ".FlushD"},    int'(hz.FlushD),    int'(t.fd));
        chk({tag, ".ForwardAD"}, int'(hz.ForwardAD), int'(t.fad));
        chk({tag, ".ForwardBD"}, int'(hz.ForwardBD), int'(t.fbd));
        chk({tag, ".ForwardAE"}, int'(hz.ForwardAE), int'(t.fae));
        chk({tag, ".ForwardBE"}, int'(hz.ForwardBE), int'(t.fbe));
        chk({tag, ".StallCnt"},  int'(hz.StallCnt),  int'(t.cnt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t nop;
        vec_t lwA;
        vec_t useB;
        totalChecks  = 0;
        passedChecks = 0;

        //       v rs rt rp tp rw ld wr br jr tk  st fd fad fbd fae fbe cnt
        // lw $8 ; add $9,$8,$10 : one load-use stall, then WB forward in EX
        tbl.push_back(mk(1, 1, 0,1,0,1,1, 8,0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1, 8,10,1,1,1,0, 9,0,0,0, 1,0,0,0,0,0,0));
        tbl.push_back(mk(1, 8,10,1,1,1,0, 9,0,0,0, 0,0,0,0,0,0,1));
        tbl.push_back(mk(0, 0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0,2,0,1));
        // add $3 ; sub $4,$3,$3 ; or $7,$3,$0 : ALU chain
        tbl.push_back(mk(1, 1, 2,1,1,1,0, 3,0,0,0, 0,0,0,0,0,0,1));
        tbl.push_back(mk(1, 3, 3,1,1,1,0, 4,0,0,0, 0,0,0,0,0,0,1));
        tbl.push_back(mk(1, 3, 0,1,1,1,0, 7,0,0,0, 0,0,1,0,1,1,1));
        tbl.push_back(mk(0, 0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0,2,0,1));
        // lw $5 ; beq $5,$6 taken : two stall cycles, flush only on the third
        tbl.push_back(mk(1, 1, 0,1,0,1,1, 5,0,0,0, 0,0,0,0,0,0,1));
        tbl.push_back(mk(1, 5, 6,1,1,0,0, 0,1,0,1, 1,0,0,0,0,0,1));
        tbl.push_back(mk(1, 5, 6,1,1,0,0, 0,1,0,1, 1,0,0,0,0,0,2));
        tbl.push_back(mk(1, 5, 6,1,1,0,0, 0,1,0,1, 0,1,2,0,0,0,3));
        // lw $0 ; beq $0,$0 ; add $9,$0,$0 : register zero never hazards
        tbl.push_back(mk(1, 1, 0,1,0,1,1, 0,0,0,0, 0,0,0,0,0,0,3));
        tbl.push_back(mk(1, 0, 0,1,1,0,0, 0,1,0,0, 0,0,0,0,0,0,3));
        tbl.push_back(mk(1, 0, 0,1,1,1,0, 9,0,0,0, 0,0,0,0,0,0,3));
        tbl.push_back(mk(0, 0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,3));
        // add $10 ; jr $10 : one stall, then MEM forward and flush
        tbl.push_back(mk(1, 1, 0,1,0,1,0,10,0,0,0, 0,0,0,0,0,0,3));
        tbl.push_back(mk(1,10, 0,1,0,0,0, 0,0,1,1, 1,0,0,0,0,0,3));
        tbl.push_back(mk(1,10, 0,1,0,0,0, 0,0,1,1, 0,1,1,0,0,0,4));
        tbl.push_back(mk(0, 0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0,2,0,4));
        // two writes of $11 : MEM beats WB; a source that is not read is ignored
        tbl.push_back(mk(1, 1, 0,1,0,1,0,11,0,0,0, 0,0,0,0,0,0,4));
        tbl.push_back(mk(1, 1, 0,1,0,1,0,11,0,0,0, 0,0,0,0,0,0,4));
        tbl.push_back(mk(0, 0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,4));
        tbl.push_back(mk(1,11,11,1,1,0,0, 0,0,0,0, 0,0,1,1,0,0,4));
        tbl.push_back(mk(1,11, 0,0,0,0,0, 0,0,0,0, 0,0,0,0,2,2,4));
        tbl.push_back(mk(0, 0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,4));

        nop  = mk(0, 0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0);
        lwA  = mk(1, 1, 0,1,0,1,1, 8,0,0,0, 0,0,0,0,0,0,0);
        useB = mk(1, 8, 9,1,1,1,0, 9,0,0,0, 1,0,0,0,0,0,0);

        // Reset with a hazard-shaped instruction present: all controls stay low.
        reset = 1'b1;
        applyStimulus(useB);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst.StallF",    int'(hz.StallF),    0);
        chk("rst.FlushD",    int'(hz.FlushD),    0);
        chk("rst.ForwardAD", int'(hz.ForwardAD), 0);
        chk("rst.ForwardAE", int'(hz.ForwardAE), 0);
        chk("rst.StallCnt",  int'(hz.StallCnt),  0);
        applyStimulus(nop);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i], $sformatf("vec%0d", i));
        end

        // Alternating lw/use pairs: one stall per pair, counter pins at all-ones.
        for (int p = 0; p < 21; p++) begin
            applyStimulus(lwA);
            @(posedge clk);
            #1;
            applyStimulus(useB);
            @(negedge clk);
            chk($sformatf("sat%0d.StallF", p), int'(hz.StallF), 1);
            @(posedge clk);
            #1;
            if (p == 10) chk("sat.cntAtMax", int'(hz.StallCnt), 15);
        end
        chk("sat.cntNoWrap", int'(hz.StallCnt), 15);

        // Reset in the middle of a load-use stall.
        applyStimulus(lwA);
        @(posedge clk);
        #1;
        applyStimulus(useB);
        @(negedge clk);
        chk("midrst.preStall", int'(hz.StallF), 1);
        reset = 1'b1;
        #1;
        chk("midrst.during", int'(hz.StallF), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst.StallF",    int'(hz.StallF),    0);
        chk("midrst.FlushE",    int'(hz.FlushE),    0);
        chk("midrst.StallCnt",  int'(hz.StallCnt),  0);
        chk("midrst.ForwardAD", int'(hz.ForwardAD), 0);
        chk("midrst.ForwardAE", int'(hz.ForwardAE), 0);
        @(posedge clk);
        #1;
        applyStimulus(nop);
        @(negedge clk);
        chk("midrst.ForwardAE2", int'(hz.ForwardAE), 0);
        chk("midrst.ForwardBE2", int'(hz.ForwardBE), 0);

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
